// File: rtl/dk_pkg.sv
// Shared types and constants for the Mario death/respawn controller.
package dk_pkg;

    localparam int unsigned LIVES_W = 2;
    localparam int unsigned FCNT_W  = 8;
    localparam int unsigned ANIM_W  = 2;

    localparam int unsigned DEF_START_LIVES  = 3;
    localparam int unsigned DEF_HIT_FRAMES   = 30;
    localparam int unsigned DEF_ANIM_FRAMES  = 8;
    localparam int unsigned DEF_ANIM_STEPS   = 4;
    localparam int unsigned DEF_GRACE_FRAMES = 120;

    typedef enum logic [2:0] {
        IDLE,
        PLAY,
        HIT,
        DYING,
        GRACE,
        OVER
    } death_state_t;

    typedef struct packed {
        logic               freeze;
        logic               dying;
        logic [ANIM_W-1:0]  anim_step;
        logic               mario_visible;
        logic               respawn;
        logic [LIVES_W-1:0] lives;
        logic               game_over;
    } death_out_t;

endpackage

// File: rtl/frame_timer.sv
// Frame-tick counter with synchronous clear and a terminal-count compare,
// shared by every timed phase of the death controller.
module frame_timer
    import dk_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_clear,
    input  logic              i_tick,
    input  logic [FCNT_W-1:0] i_term,
    output logic [FCNT_W-1:0] o_fcnt_nxt_c,
    output logic              o_done_c
);

    logic [FCNT_W-1:0] r_fcnt;

    // Clear wins over a coincident tick.
    always_comb begin
        o_fcnt_nxt_c = r_fcnt;
        if (i_clear) begin
            o_fcnt_nxt_c = '0;
        end else if (i_tick) begin
            o_fcnt_nxt_c = r_fcnt + FCNT_W'(1);
        end
    end

    assign o_done_c = i_tick && (r_fcnt == i_term);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_fcnt <= '0;
        end else begin
            r_fcnt <= o_fcnt_nxt_c;
        end
    end

endmodule

// File: rtl/mario_death_ctrl.sv
// Mario hit/death/respawn sequencer with lives and game-over handling.
// Define GRACE_BLINK_EN to blink Mario during post-respawn invulnerability.
module mario_death_ctrl
    import dk_pkg::*;
#(
    parameter int unsigned START_LIVES  = DEF_START_LIVES,
    parameter int unsigned HIT_FRAMES   = DEF_HIT_FRAMES,
    parameter int unsigned ANIM_FRAMES  = DEF_ANIM_FRAMES,
    parameter int unsigned ANIM_STEPS   = DEF_ANIM_STEPS,
    parameter int unsigned GRACE_FRAMES = DEF_GRACE_FRAMES
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_tick,
    input  logic               collision,
    input  logic               game_start,
    output logic               freeze,
    output logic               dying,
    output logic [ANIM_W-1:0]  anim_step,
    output logic               mario_visible,
    output logic               respawn,
    output logic [LIVES_W-1:0] lives,
    output logic               game_over
);

    localparam logic [FCNT_W-1:0]  HIT_TERM   = FCNT_W'(HIT_FRAMES - 1);
    localparam logic [FCNT_W-1:0]  ANIM_TERM  = FCNT_W'(ANIM_STEPS * ANIM_FRAMES - 1);
    localparam logic [FCNT_W-1:0]  GRACE_TERM = FCNT_W'(GRACE_FRAMES - 1);
    localparam logic [FCNT_W-1:0]  ANIM_DIV   = FCNT_W'(ANIM_FRAMES);
    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(START_LIVES);

    death_state_t       r_state;
    death_state_t       w_state_nxt;
    death_out_t         r_out;
    death_out_t         w_out_nxt;
    logic               w_clear;
    logic [FCNT_W-1:0]  w_term;
    logic [FCNT_W-1:0]  w_fcnt_nxt;
    logic               w_done;
    logic [LIVES_W-1:0] w_lives_nxt;
    logic               w_respawn_nxt;

    frame_timer u_frame_timer (
        .i_clk        (Clk),
        .i_reset      (Reset),
        .i_clear      (w_clear),
        .i_tick       (frame_tick),
        .i_term       (w_term),
        .o_fcnt_nxt_c (w_fcnt_nxt),
        .o_done_c     (w_done)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state               <= IDLE;
            r_out.freeze          <= 1'b1;
            r_out.dying           <= 1'b0;
            r_out.anim_step       <= '0;
            r_out.mario_visible   <= 1'b1;
            r_out.respawn         <= 1'b0;
            r_out.lives           <= LIVES_INIT;
            r_out.game_over       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_out   <= w_out_nxt;
        end
    end

    // Next state, timer control and lives bookkeeping.
    always_comb begin
        w_state_nxt   = r_state;
        w_clear       = 1'b0;
        w_term        = '0;
        w_lives_nxt   = r_out.lives;
        w_respawn_nxt = 1'b0;
        case (r_state)
            IDLE, OVER: begin
                w_clear = 1'b1;
                if (game_start) begin
                    w_lives_nxt   = LIVES_INIT;
                    w_respawn_nxt = 1'b1;
                    w_state_nxt   = PLAY;
                end
            end
            PLAY: begin
                w_clear = 1'b1;
                if (collision) begin
                    w_state_nxt = HIT;
                end
            end
            HIT: begin
                w_term = HIT_TERM;
                if (w_done) begin
                    w_clear     = 1'b1;
                    w_state_nxt = DYING;
                end
            end
            DYING: begin
                w_term = ANIM_TERM;
                if (w_done) begin
                    w_clear = 1'b1;
                    if (r_out.lives <= LIVES_W'(1)) begin
                        w_lives_nxt = '0;
                        w_state_nxt = OVER;
                    end else begin
                        w_lives_nxt   = r_out.lives - LIVES_W'(1);
                        w_respawn_nxt = 1'b1;
                        w_state_nxt   = GRACE;
                    end
                end
            end
            GRACE: begin
                w_term = GRACE_TERM;
                if (w_done) begin
                    w_clear     = 1'b1;
                    w_state_nxt = PLAY;
                end
            end
            default: begin
                w_clear     = 1'b1;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Outputs decoded from the upcoming state so they line up with it after the edge.
    always_comb begin
        w_out_nxt               = '0;
        w_out_nxt.freeze        = !((w_state_nxt == PLAY) || (w_state_nxt == GRACE));
        w_out_nxt.dying         = (w_state_nxt == DYING);
        w_out_nxt.anim_step     = (w_state_nxt == DYING) ? ANIM_W'(w_fcnt_nxt / ANIM_DIV) : '0;
        w_out_nxt.mario_visible = 1'b1;
`ifdef GRACE_BLINK_EN
        if (w_state_nxt == GRACE) begin
            w_out_nxt.mario_visible = ~w_fcnt_nxt[2];
        end
`else
`endif
        w_out_nxt.respawn       = w_respawn_nxt;
        w_out_nxt.lives         = w_lives_nxt;
        w_out_nxt.game_over     = (w_state_nxt == OVER);
    end

    assign freeze        = r_out.freeze;
    assign dying         = r_out.dying;
    assign anim_step     = r_out.anim_step;
    assign mario_visible = r_out.mario_visible;
    assign respawn       = r_out.respawn;
    assign lives         = r_out.lives;
    assign game_over     = r_out.game_over;

endmodule

// File: tb/tb_mario_death_ctrl.sv
// Bench for mario_death_ctrl: directed scenarios plus randomized traffic
// checked against a frame-counting reference model.
module tb_mario_death_ctrl;

    localparam int P_START = 3;
    localparam int P_HIT   = 2;
    localparam int P_ANIM  = 2;
    localparam int P_STEPS = 4;
    localparam int P_GRACE = 4;

    localparam int M_IDLE  = 0;
    localparam int M_PLAY  = 1;
    localparam int M_HIT   = 2;
    localparam int M_DYING = 3;
    localparam int M_GRACE = 4;
    localparam int M_OVER  = 5;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       collision = 1'b0;
    logic       game_start = 1'b0;
    logic       freeze;
    logic       dying;
    logic [1:0] anim_step;
    logic       mario_visible;
    logic       respawn;
    logic [1:0] lives;
    logic       game_over;

    int checks = 0;
    int failures = 0;

    int m_mode = M_IDLE;
    int m_frames = 0;
    int m_lives = P_START;
    bit m_resp = 1'b0;

    always #5 Clk = ~Clk;

    mario_death_ctrl #(
        .START_LIVES  (P_START),
        .HIT_FRAMES   (P_HIT),
        .ANIM_FRAMES  (P_ANIM),
        .ANIM_STEPS   (P_STEPS),
        .GRACE_FRAMES (P_GRACE)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .frame_tick    (frame_tick),
        .collision     (collision),
        .game_start    (game_start),
        .freeze        (freeze),
        .dying         (dying),
        .anim_step     (anim_step),
        .mario_visible (mario_visible),
        .respawn       (respawn),
        .lives         (lives),
        .game_over     (game_over)
    );

    function automatic logic [8:0] dut_vec();
        return {freeze, dying, anim_step, mario_visible, respawn, lives, game_over};
    endfunction

    function automatic logic [8:0] exp_vec();
        logic       fz;
        logic       dy;
        logic       vis;
        logic       go;
        logic [1:0] an;
        fz  = !(m_mode == M_PLAY || m_mode == M_GRACE);
        dy  = (m_mode == M_DYING);
        go  = (m_mode == M_OVER);
        an  = dy ? 2'(m_frames / P_ANIM) : 2'd0;
        vis = 1'b1;
`ifdef GRACE_BLINK_EN
        if (m_mode == M_GRACE) vis = ((m_frames / 4) % 2) == 0;
`endif
        return {fz, dy, an, vis, m_resp, 2'(m_lives), go};
    endfunction

    // Rules stated in frames elapsed per phase; updated once per clock edge.
    task automatic model_step(input logic t, input logic c, input logic g, input logic r);
        m_resp = 1'b0;
        if (r) begin
            m_mode = M_IDLE; m_frames = 0; m_lives = P_START;
        end else begin
            case (m_mode)
                M_IDLE, M_OVER: if (g) begin
                    m_mode = M_PLAY; m_frames = 0; m_lives = P_START; m_resp = 1'b1;
                end
                M_PLAY: if (c) begin
                    m_mode = M_HIT; m_frames = 0;
                end
                M_HIT: if (t) begin
                    m_frames++;
                    if (m_frames == P_HIT) begin m_mode = M_DYING; m_frames = 0; end
                end
                M_DYING: if (t) begin
                    m_frames++;
                    if (m_frames == P_STEPS * P_ANIM) begin
                        m_frames = 0;
                        m_lives  = (m_lives > 0) ? m_lives - 1 : 0;
                        if (m_lives == 0) m_mode = M_OVER;
                        else begin m_mode = M_GRACE; m_resp = 1'b1; end
                    end
                end
                M_GRACE: if (t) begin
                    m_frames++;
                    if (m_frames == P_GRACE) begin m_mode = M_PLAY; m_frames = 0; end
                end
                default: ;
            endcase
        end
    endtask

    task automatic step(input logic t, input logic c, input logic g, input logic r);
        frame_tick = t; collision = c; game_start = g; Reset = r;
        @(posedge Clk);
        model_step(t, c, g, r);
        #1;
        frame_tick = 1'b0; collision = 1'b0; game_start = 1'b0; Reset = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (dut_vec() !== {1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 2'd3, 1'b0}) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected %b", dut_vec(), {1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 2'd3, 1'b0});
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({freeze, respawn, game_over} !== 3'b100) begin
            failures++;
            $display("FAIL idle_hold: got %b expected 100", {freeze, respawn, game_over});
        end
    endtask

    task automatic test_start();
        step(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({freeze, respawn, lives} !== {1'b0, 1'b1, 2'd3}) begin
            failures++;
            $display("FAIL start_respawn: got %b expected 0111", {freeze, respawn, lives});
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({freeze, respawn} !== 2'b00) begin
            failures++;
            $display("FAIL start_pulse_width: got %b expected 00", {freeze, respawn});
        end
    endtask

    task automatic test_death();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({freeze, dying} !== 2'b10) begin
            failures++;
            $display("FAIL hit_freeze: got %b expected 10", {freeze, dying});
        end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({freeze, dying} !== 2'b10) begin
            failures++;
            $display("FAIL hit_one_tick: got %b expected 10", {freeze, dying});
        end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({dying, anim_step} !== 3'b100) begin
            failures++;
            $display("FAIL dying_start: got %b expected 100", {dying, anim_step});
        end
        for (int k = 1; k <= 8; k++) begin
            int idle_n;
            idle_n = $urandom_range(0, 2);
            for (int j = 0; j < idle_n; j++) step(1'b0, 1'b0, 1'b0, 1'b0);
            step(1'b1, 1'b0, 1'b0, 1'b0);
            checks++;
            if (k < 8) begin
                if ({dying, anim_step, lives} !== {1'b1, 2'(k / 2), 2'd3}) begin
                    failures++;
                    $display("FAIL anim_step k=%0d: got %b expected %b", k, {dying, anim_step, lives}, {1'b1, 2'(k / 2), 2'd3});
                end
            end else begin
                if ({dying, freeze, respawn, lives} !== {1'b0, 1'b0, 1'b1, 2'd2}) begin
                    failures++;
                    $display("FAIL death_exit: got %b expected 00110", {dying, freeze, respawn, lives});
                end
            end
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({respawn, lives} !== {1'b0, 2'd2}) begin
            failures++;
            $display("FAIL death_respawn_once: got %b expected 010", {respawn, lives});
        end
    endtask

    task automatic test_grace_collision();
        for (int k = 1; k <= 4; k++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            step(1'b1, 1'b1, 1'b0, 1'b0);
            checks++;
            if ({freeze, dying} !== 2'b00 || dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL grace_ignores_collision k=%0d: got %b expected %b", k, dut_vec(), exp_vec());
            end
        end
        step(1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({freeze, dying} !== 2'b10) begin
            failures++;
            $display("FAIL play_after_grace_hit: got %b expected 10", {freeze, dying});
        end
    endtask

    task automatic test_game_over();
        ticks(10);
        checks++;
        if ({lives, respawn} !== {2'd1, 1'b1}) begin
            failures++;
            $display("FAIL second_death: got %b expected 011", {lives, respawn});
        end
        ticks(4);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(10);
        checks++;
        if ({lives, game_over, respawn, freeze} !== {2'd0, 1'b1, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL game_over_entry: got %b expected 00101", {lives, game_over, respawn, freeze});
        end
        step(1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({lives, game_over, respawn} !== {2'd0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL game_over_hold: got %b expected 0010", {lives, game_over, respawn});
        end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({lives, game_over, respawn, freeze} !== {2'd3, 1'b0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL restart: got %b expected 11010", {lives, game_over, respawn, freeze});
        end
    endtask

    task automatic test_reset_mid_dying();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(10);
        ticks(4);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(2);
        ticks(4);
        checks++;
        if ({dying, anim_step, lives} !== {1'b1, 2'd2, 2'd2}) begin
            failures++;
            $display("FAIL mid_dying_setup: got %b expected 11010", {dying, anim_step, lives});
        end
        step(1'b1, 1'b0, 1'b0, 1'b1);
        checks++;
        if ({freeze, dying, anim_step, lives, respawn, game_over} !== {1'b1, 1'b0, 2'd0, 2'd3, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_mid_dying: got %b expected 10001100", {freeze, dying, anim_step, lives, respawn, game_over});
        end
    endtask

    task automatic test_tick_collision_same();
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({freeze, dying} !== 2'b10) begin
            failures++;
            $display("FAIL same_cycle_hit: got %b expected 10", {freeze, dying});
        end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (dying !== 1'b0) begin
            failures++;
            $display("FAIL same_cycle_fcnt_cleared: got %b expected 0", dying);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(8);
        for (int f = 0; f < 4; f++) begin
            checks++;
            if (mario_visible !== 1'b1 || freeze !== 1'b0) begin
                failures++;
                $display("FAIL grace_visible f=%0d: got %b expected 10", f, {mario_visible, freeze});
            end
            step(1'b1, 1'b0, 1'b0, 1'b0);
        end
        checks++;
        if ({mario_visible, freeze, dut_vec() === exp_vec()} !== 3'b101) begin
            failures++;
            $display("FAIL grace_exit: got %b expected %b", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        logic prev_resp;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        prev_resp = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 5) == 0),
                 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 299) == 0));
            checks++;
            if (dut_vec() !== exp_vec() || (prev_resp && respawn)) begin
                failures++;
                $display("FAIL random_cycle %0d: got %b expected %b", i, dut_vec(), exp_vec());
            end
            prev_resp = respawn;
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_death();
        test_grace_collision();
        test_game_over();
        test_reset_mid_dying();
        test_tick_collision_same();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
